conv_pool_sched: RTL and testbench

Top-level sequencer for the CONV engine: drives the image-ROM address, 3x3 tap and zero-padding control for the external MAC/ReLU datapath, and the layer memory read/write strobes.
- Layer 0: 3x3 convolution over a 64x64 image; 4096 results written with csel=001.
- Layer 1: 2x2 max-pool reading layer 0 back; 1024 results written with csel=011.
- Owns busy/ready handshake and all csel/cwr/crd timing. Datapath holds arithmetic only.

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/conv_tap_addr.sv | 34 +++
 rtl/conv_pool_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_conv_pool_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the CONV/POOL sequencer.
package conv_pkg;

  localparam int IMG_W_LOG2_DEF = 6;
  localparam int TAPS           = 9;
  localparam int POOL_SAMPLES   = 4;

  localparam logic [3:0] LAST_TAP    = 4'(TAPS - 1);
  localparam logic [1:0] LAST_SAMPLE = 2'(POOL_SAMPLES - 1);

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  // Two-bit two's complement kernel offsets.
  localparam logic [1:0] OFF_NEG  = 2'b11;
  localparam logic [1:0] OFF_ZERO = 2'b00;
  localparam logic [1:0] OFF_POS  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV_TAP  = 3'd1,
    S_CONV_WR   = 3'd2,
    S_POOL_RD   = 3'd3,
    S_POOL_WAIT = 3'd4,
    S_POOL_WR   = 3'd5
  } state_e;

  // Row offset of kernel tap k (taps laid out row-major, 3 per row).
  function automatic logic [1:0] tap_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_dy = OFF_NEG;
      4'd3, 4'd4, 4'd5: tap_dy = OFF_ZERO;
      default:          tap_dy = OFF_POS;
    endcase
  endfunction

  // Column offset of kernel tap k.
  function automatic logic [1:0] tap_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_dx = OFF_NEG;
      4'd1, 4'd4, 4'd7: tap_dx = OFF_ZERO;
      default:          tap_dx = OFF_POS;
    endcase
  endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Maps (row, col, tap) to an image address, flagging taps that fall off
// the image edge so the datapath substitutes zero.
module conv_tap_addr
  import conv_pkg::*;
#(
  parameter int IMG_W_LOG2 = IMG_W_LOG2_DEF
) (
  input  logic [IMG_W_LOG2-1:0]   row,
  input  logic [IMG_W_LOG2-1:0]   col,
  input  logic [3:0]              tap,
  output logic [2*IMG_W_LOG2-1:0] iaddr,
  output logic                    pad
);

  // Two guard bits: 11 means the coordinate went negative, 01 means it
  // reached the image width; either way the tap is padding.
  localparam int EW = IMG_W_LOG2 + 2;

  logic [EW-1:0] r_ext;
  logic [EW-1:0] c_ext;
  logic [1:0]    dy;
  logic [1:0]    dx;

  // Offset the pixel by the tap's kernel position and bounds-check it.
  always_comb begin
    dy    = tap_dy(tap);
    dx    = tap_dx(tap);
    r_ext = {2'b00, row} + {{IMG_W_LOG2{dy[1]}}, dy};
    c_ext = {2'b00, col} + {{IMG_W_LOG2{dx[1]}}, dx};
    pad   = (r_ext[EW-1:IMG_W_LOG2] != 2'b00) || (c_ext[EW-1:IMG_W_LOG2] != 2'b00);
    iaddr = pad ? '0 : {r_ext[IMG_W_LOG2-1:0], c_ext[IMG_W_LOG2-1:0]};
  end

endmodule

// File: rtl/conv_pool_sched.sv
// Sequencer for the CONV engine: 3x3 convolution (layer 0) followed by
// 2x2 max-pool (layer 1). All outputs come straight from flops; the
// registered output values are computed from the next-state counters so
// every output lines up with the state it belongs to.
// Handshake: ready is a level request sampled only in IDLE; busy is high
// from the accepting edge until the edge after the last layer-1 write.
module conv_pool_sched
  import conv_pkg::*;
#(
  parameter int IMG_W_LOG2 = IMG_W_LOG2_DEF,
  parameter int ADDR_W     = 2 * IMG_W_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic [3:0]        tap_idx,
  output logic              pad,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  output logic              pool_vld,
  output logic              pool_first,
  output logic [2:0]        dbg_state
);

  localparam int PW = IMG_W_LOG2 - 1;

  state_e                state_q, state_d;
  logic [IMG_W_LOG2-1:0] row_q, row_d, col_q, col_d;
  logic [3:0]            tap_q, tap_d;
  logic [PW-1:0]         pr_q, pr_d, pc_q, pc_d;
  logic [1:0]            q_q, q_d;

  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     iaddr_q, iaddr_d;
  logic [3:0]            tap_idx_q, tap_idx_d;
  logic                  pad_q, pad_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  mac_en_q, mac_en_d;
  logic                  cwr_q, cwr_d;
  logic [ADDR_W-1:0]     caddr_wr_q, caddr_wr_d;
  logic                  crd_q, crd_d;
  logic [ADDR_W-1:0]     caddr_rd_q, caddr_rd_d;
  logic [2:0]            csel_q, csel_d;
  logic                  pool_vld_q, pool_vld_d;
  logic                  pool_first_q, pool_first_d;

  logic [ADDR_W-1:0]     tap_iaddr;
  logic                  tap_pad;

  conv_tap_addr #(.IMG_W_LOG2(IMG_W_LOG2)) u_tap_addr (
    .row   (row_d),
    .col   (col_d),
    .tap   (tap_d),
    .iaddr (tap_iaddr),
    .pad   (tap_pad)
  );

  // Next state and counters; counters only wrap on explicit transitions.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    q_d     = q_q;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_CONV_TAP;
          row_d   = '0;
          col_d   = '0;
          tap_d   = '0;
        end
      end
      S_CONV_TAP: begin
        if (tap_q == LAST_TAP) state_d = S_CONV_WR;
        else                   tap_d   = tap_q + 4'd1;
      end
      S_CONV_WR: begin
        tap_d = '0;
        if ((&row_q) && (&col_q)) begin
          state_d = S_POOL_RD;
          row_d   = '0;
          col_d   = '0;
          pr_d    = '0;
          pc_d    = '0;
          q_d     = '0;
        end else begin
          state_d        = S_CONV_TAP;
          {row_d, col_d} = {row_q, col_q} + 1'b1;
        end
      end
      S_POOL_RD: begin
        if (q_q == LAST_SAMPLE) state_d = S_POOL_WAIT;
        else                    q_d     = q_q + 2'd1;
      end
      S_POOL_WAIT: state_d = S_POOL_WR;
      S_POOL_WR: begin
        q_d = '0;
        if ((&pr_q) && (&pc_q)) begin
          state_d = S_IDLE;
          pr_d    = '0;
          pc_d    = '0;
        end else begin
          state_d      = S_POOL_RD;
          {pr_d, pc_d} = {pr_q, pc_q} + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the cycle being entered, decoded from next state.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    iaddr_d      = '0;
    tap_idx_d    = '0;
    pad_d        = 1'b0;
    mac_clr_d    = 1'b0;
    mac_en_d     = 1'b0;
    cwr_d        = 1'b0;
    caddr_wr_d   = '0;
    crd_d        = 1'b0;
    caddr_rd_d   = '0;
    csel_d       = CSEL_NONE;
    pool_vld_d   = crd_q;
    pool_first_d = (state_q == S_POOL_RD) && (q_q == 2'd0);
    case (state_d)
      S_CONV_TAP: begin
        mac_en_d  = 1'b1;
        mac_clr_d = (tap_d == 4'd0);
        tap_idx_d = tap_d;
        iaddr_d   = tap_iaddr;
        pad_d     = tap_pad;
      end
      S_CONV_WR: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_wr_d = {row_d, col_d};
      end
      S_POOL_RD: begin
        crd_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_rd_d = {pr_d, q_d[1], pc_d, q_d[0]};
      end
      S_POOL_WAIT: csel_d = CSEL_L0;
      S_POOL_WR: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L1;
        caddr_wr_d = {2'b00, pr_d, pc_d};
      end
      default: ;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      tap_q        <= '0;
      pr_q         <= '0;
      pc_q         <= '0;
      q_q          <= '0;
      busy_q       <= 1'b0;
      iaddr_q      <= '0;
      tap_idx_q    <= '0;
      pad_q        <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      cwr_q        <= 1'b0;
      caddr_wr_q   <= '0;
      crd_q        <= 1'b0;
      caddr_rd_q   <= '0;
      csel_q       <= CSEL_NONE;
      pool_vld_q   <= 1'b0;
      pool_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tap_q        <= tap_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      q_q          <= q_d;
      busy_q       <= busy_d;
      iaddr_q      <= iaddr_d;
      tap_idx_q    <= tap_idx_d;
      pad_q        <= pad_d;
      mac_clr_q    <= mac_clr_d;
      mac_en_q     <= mac_en_d;
      cwr_q        <= cwr_d;
      caddr_wr_q   <= caddr_wr_d;
      crd_q        <= crd_d;
      caddr_rd_q   <= caddr_rd_d;
      csel_q       <= csel_d;
      pool_vld_q   <= pool_vld_d;
      pool_first_q <= pool_first_d;
    end
  end

  assign busy       = busy_q;
  assign iaddr      = iaddr_q;
  assign tap_idx    = tap_idx_q;
  assign pad        = pad_q;
  assign mac_clr    = mac_clr_q;
  assign mac_en     = mac_en_q;
  assign cwr        = cwr_q;
  assign caddr_wr   = caddr_wr_q;
  assign crd        = crd_q;
  assign caddr_rd   = caddr_rd_q;
  assign csel       = csel_q;
  assign pool_vld   = pool_vld_q;
  assign pool_first = pool_first_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_pool_sched.sv
// Bench for conv_pool_sched: scoreboard queues hold every expected tap,
// write and read event stamped with its cycle offset from the start edge.
module tb_conv_pool_sched;

  localparam int BUSY_CYC = 4096 * 10 + 1024 * 6;
  localparam int EW       = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic ready;
  always #5 clk = ~clk;

  logic        busy, pad, mac_clr, mac_en, cwr, crd, pool_vld, pool_first;
  logic [11:0] iaddr, caddr_wr, caddr_rd;
  logic [3:0]  tap_idx;
  logic [2:0]  csel, dbg_state;
  logic [50:0] all_outs;

  assign all_outs = {busy, mac_clr, mac_en, cwr, crd, pad, pool_vld, pool_first,
                     csel, tap_idx, iaddr, caddr_wr, caddr_rd};

  conv_pool_sched dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .busy       (busy),
    .iaddr      (iaddr),
    .tap_idx    (tap_idx),
    .pad        (pad),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .csel       (csel),
    .pool_vld   (pool_vld),
    .pool_first (pool_first),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: [39:24] cycle offset, [23:0] payload.
  logic [EW-1:0] tap_exp_q[$];
  logic [EW-1:0] wr_exp_q[$];
  logic [EW-1:0] rd_exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;
  int rd_idx;
  bit prev_rd, prev_first;

  logic [EW-1:0] m_e;
  logic [23:0]   m_obs;
  bit            m_tap_now, m_wr_now, m_rd_now;

  task automatic fill_queues();
    logic [EW-1:0] e;
    int r, c, a;
    bit pd;
    tap_exp_q.delete();
    wr_exp_q.delete();
    rd_exp_q.delete();
    for (int p = 0; p < 4096; p++) begin
      for (int k = 0; k < 9; k++) begin
        r  = p / 64 + k / 3 - 1;
        c  = p % 64 + k % 3 - 1;
        pd = (r < 0) || (r > 63) || (c < 0) || (c > 63);
        a  = pd ? 0 : r * 64 + c;
        e  = '0;
        e[39:24] = 16'(10 * p + k);
        e[23:0]  = 24'({3'b000, pd, 12'(a), 4'(k), (k == 0)});
        tap_exp_q.push_back(e);
      end
      e = '0;
      e[39:24] = 16'(10 * p + 9);
      e[23:0]  = 24'({3'b001, 12'(p)});
      wr_exp_q.push_back(e);
    end
    for (int w = 0; w < 1024; w++) begin
      for (int q = 0; q < 4; q++) begin
        e = '0;
        e[39:24] = 16'(40960 + 6 * w + q);
        e[23:0]  = 24'({3'b001, 12'((2 * (w / 32) + q / 2) * 64 + 2 * (w % 32) + q % 2)});
        rd_exp_q.push_back(e);
      end
      e = '0;
      e[39:24] = 16'(40960 + 6 * w + 5);
      e[23:0]  = 24'({3'b011, 12'(w)});
      wr_exp_q.push_back(e);
    end
  endtask

  // Per-cycle monitor: pops an entry whenever its cycle stamp is due.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc <= BUSY_CYC) begin
        total++;
        if (busy !== (cyc < BUSY_CYC)) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc < BUSY_CYC));
        end
      end
      m_tap_now = (tap_exp_q.size() > 0) && (tap_exp_q[0][39:24] == 16'(cyc));
      m_wr_now  = (wr_exp_q.size() > 0) && (wr_exp_q[0][39:24] == 16'(cyc));
      m_rd_now  = (rd_exp_q.size() > 0) && (rd_exp_q[0][39:24] == 16'(cyc));
      total++;
      if (mac_en !== m_tap_now) begin
        bad++;
        $display("FAIL mac_en cyc=%0d got=%b exp=%b", cyc, mac_en, m_tap_now);
      end
      if (m_tap_now) begin
        m_e   = tap_exp_q.pop_front();
        m_obs = 24'({csel, pad, iaddr, tap_idx, mac_clr});
        total++;
        if (m_obs !== m_e[23:0]) begin
          bad++;
          $display("FAIL tap cyc=%0d got{csel,pad,iaddr,tap,clr}=%h exp=%h", cyc, m_obs, m_e[23:0]);
        end
      end
      total++;
      if (cwr !== m_wr_now) begin
        bad++;
        $display("FAIL cwr cyc=%0d got=%b exp=%b", cyc, cwr, m_wr_now);
      end
      if (m_wr_now) begin
        m_e   = wr_exp_q.pop_front();
        m_obs = 24'({csel, caddr_wr});
        total++;
        if (m_obs !== m_e[23:0]) begin
          bad++;
          $display("FAIL wr cyc=%0d got{csel,addr}=%h exp=%h", cyc, m_obs, m_e[23:0]);
        end
      end
      total++;
      if (crd !== m_rd_now) begin
        bad++;
        $display("FAIL crd cyc=%0d got=%b exp=%b", cyc, crd, m_rd_now);
      end
      if (m_rd_now) begin
        m_e   = rd_exp_q.pop_front();
        m_obs = 24'({csel, caddr_rd});
        total++;
        if (m_obs !== m_e[23:0]) begin
          bad++;
          $display("FAIL rd cyc=%0d got{csel,addr}=%h exp=%h", cyc, m_obs, m_e[23:0]);
        end
      end
      total++;
      if ({pool_vld, pool_first} !== {prev_rd, prev_first}) begin
        bad++;
        $display("FAIL pool_flags cyc=%0d got=%b%b exp=%b%b", cyc, pool_vld, pool_first, prev_rd, prev_first);
      end
      prev_first = m_rd_now && (rd_idx % 4 == 0);
      if (m_rd_now) rd_idx++;
      prev_rd = m_rd_now;
      cyc++;
      if (cyc > BUSY_CYC) mon_on = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Raise ready and arm the monitor so that cycle 0 is the first busy cycle.
  task automatic start_run();
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    cyc        = 0;
    rd_idx     = 0;
    prev_rd    = 1'b0;
    prev_first = 1'b0;
    mon_on     = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0", all_outs);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL idle_no_ready got=%h exp=0", all_outs);
    end
  endtask

  // Full run with ready toggling randomly; ends with ready held high to
  // show IDLE re-arming.
  task automatic test_full_run();
    fill_queues();
    start_run();
    for (int i = 0; i < BUSY_CYC + 20 && mon_on; i++) begin
      @(negedge clk);
      #1;
      if (cyc < BUSY_CYC - 50) ready = 1'($urandom_range(0, 1));
      else                     ready = 1'b1;
    end
    total++;
    if (mon_on) begin
      bad++;
      $display("FAIL run_timeout cyc=%0d exp=%0d", cyc, BUSY_CYC + 1);
      mon_on = 1'b0;
    end
    total++;
    if (tap_exp_q.size() + wr_exp_q.size() + rd_exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got tap=%0d wr=%0d rd=%0d exp=0", tap_exp_q.size(), wr_exp_q.size(), rd_exp_q.size());
    end
    // One idle cycle has been checked; ready=1 must restart immediately.
    @(negedge clk);
    total++;
    if ({busy, mac_en, mac_clr, pad, tap_idx, iaddr} !== {1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 12'd0}) begin
      bad++;
      $display("FAIL rearm got busy=%b en=%b clr=%b pad=%b tap=%0d exp=1 1 1 1 0", busy, mac_en, mac_clr, pad, tap_idx);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_rearmed got=%h exp=0", all_outs);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({busy, cwr, crd} !== 3'b000) begin
        bad++;
        $display("FAIL idle_after got busy,cwr,crd=%b exp=000", {busy, cwr, crd});
      end
    end
    fill_queues();
    start_run();
    ready = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      #1;
    end
    mon_on = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL mid_reset_outs got=%h exp=0", all_outs);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_state got=%0d exp=0", dbg_state);
    end
    reset = 1'b0;
    fill_queues();
    start_run();
    total++;
    if ({mac_en, mac_clr, tap_idx, pad} !== {1'b1, 1'b1, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart_tap0 got en=%b clr=%b tap=%0d pad=%b exp=1 1 0 1", mac_en, mac_clr, tap_idx, pad);
    end
    ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
    end
    mon_on = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
